// File: rtl/dac_driver.sv
`timescale 1ns/1ps
// dac_driver
// Maps 8-bit values from the experiment FSM through a 256 x 16-bit lookup
// table and streams the resulting DAC codes over a 128-bit AXI-Stream. The
// PS loads the table over the shared GPIO write bus. A small input FIFO
// absorbs FSM bursts while the DAC applies backpressure.
//
// Ports
//   clk              single clock
//   rst              asynchronous, active-high reset
//   gpio_in          [15:0] addr, [23:16] data, [24] w_clk, [31:25] unused
//   val_in           value from the experiment FSM
//   val_in_valid     val_in is valid this cycle (never backpressured)
//   dac_run          enables beat generation toward the DAC
//   m_axis_tdata     DAC beat, sample in lane SAMPLE_LANE, other lanes zero
//   m_axis_tvalid    beat valid
//   m_axis_tready    DAC ready
//   fifo_full        input FIFO holds 2^FIFO_AW entries (registered)
//   overflow         sticky: a value arrived while the FIFO was full
//   underflow_count  saturating count of idle beats issued while running
module dac_driver #(
    parameter int LUT_PTR_REG  = 0,
    parameter int LUT_DATA_REG = 1,
    parameter int CTRL_REG     = 2,
    parameter int SAMPLE_LANE  = 6,
    parameter int FIFO_AW      = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [31:0]  gpio_in,
    input  logic [7:0]   val_in,
    input  logic         val_in_valid,
    input  logic         dac_run,
    output logic [127:0] m_axis_tdata,
    output logic         m_axis_tvalid,
    input  logic         m_axis_tready,
    output logic         fifo_full,
    output logic         overflow,
    output logic [15:0]  underflow_count
);

    localparam int               DEPTH    = 2 ** FIFO_AW;
    localparam logic [FIFO_AW:0] FULL_CNT = (FIFO_AW + 1)'(DEPTH);
    localparam logic [FIFO_AW:0] CNT_ONE  = (FIFO_AW + 1)'(1);
    localparam logic [FIFO_AW-1:0] PTR_ONE = FIFO_AW'(1);

    // ---------------------------------------------------------------
    // GPIO write strobe
    // ---------------------------------------------------------------
    logic        wclk_s1_q, wclk_s2_q, wclk_s3_q;
    logic        gpio_stb;
    logic [15:0] gpio_addr;
    logic [7:0]  gpio_data;
    logic        unused_gpio;

    assign gpio_addr   = gpio_in[15:0];
    assign gpio_data   = gpio_in[23:16];
    assign unused_gpio = ^gpio_in[31:25];

    // Rising edge seen after the two synchronizer flops; addr/data are held
    // stable by the PS for the whole w_clk high phase, so sampling them
    // directly with the strobe is safe.
    assign gpio_stb = wclk_s2_q & ~wclk_s3_q;

    logic ptr_wr, data_wr, ctrl_wr, flush, clr_stat;
    assign ptr_wr   = gpio_stb && (gpio_addr == 16'(LUT_PTR_REG));
    assign data_wr  = gpio_stb && (gpio_addr == 16'(LUT_DATA_REG));
    assign ctrl_wr  = gpio_stb && (gpio_addr == 16'(CTRL_REG));
    assign flush    = ctrl_wr & gpio_data[0];
    assign clr_stat = ctrl_wr & gpio_data[1];

    // ---------------------------------------------------------------
    // LUT write pointer / byte pairing
    // ---------------------------------------------------------------
    logic [7:0]  ptr_q, ptr_d;
    logic [7:0]  hi_q, hi_d;
    logic        toggle_q, toggle_d;
    logic        lut_we;
    logic [15:0] lut_q [256];

    assign lut_we = data_wr & toggle_q;

    always_comb begin
        ptr_d    = ptr_q;
        hi_d     = hi_q;
        toggle_d = toggle_q;
        if (ptr_wr) begin
            ptr_d    = gpio_data;
            toggle_d = 1'b0;
        end else if (data_wr) begin
            if (!toggle_q) begin
                hi_d     = gpio_data;
                toggle_d = 1'b1;
            end else begin
                ptr_d    = ptr_q + 8'd1;
                toggle_d = 1'b0;
            end
        end
    end

    // Table contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (lut_we) begin
            lut_q[ptr_q] <= {hi_q, gpio_data};
        end
    end

    // ---------------------------------------------------------------
    // Input FIFO
    // ---------------------------------------------------------------
    logic [7:0]         fifo_mem_q [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [FIFO_AW:0]   count_q, count_d;
    logic               full_q;
    logic               fifo_empty;
    logic               load, pop, push_ok, drop;

    assign fifo_empty = (count_q == '0);
    assign load       = dac_run & (~m_axis_tvalid | m_axis_tready);
    assign pop        = load & ~fifo_empty;
    // A pop in the same cycle frees the slot, so a push onto a full FIFO
    // is still accepted then.
    assign push_ok    = val_in_valid & ((count_q != FULL_CNT) | pop);
    assign drop       = val_in_valid & ~push_ok;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        case ({push_ok, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    // When full, wr_ptr equals rd_ptr; the head is read combinationally
    // before this edge overwrites it, so push+pop on a full FIFO is safe.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_mem_q[wr_ptr_q] <= val_in;
        end
    end

    // ---------------------------------------------------------------
    // Output register and status
    // ---------------------------------------------------------------
    logic [15:0]  lut_rd;
    logic [127:0] lane_beat;
    logic [127:0] tdata_q, tdata_d;
    logic         ob_valid_q, ob_valid_d;
    logic         ovf_q, ovf_d;
    logic [15:0]  uf_q, uf_d;

    // Same-cycle LUT write to this entry lands after the read: old value.
    assign lut_rd = lut_q[fifo_mem_q[rd_ptr_q]];

    always_comb begin
        lane_beat = '0;
        lane_beat[SAMPLE_LANE*16 +: 16] = lut_rd;
    end

    always_comb begin
        ob_valid_d = ob_valid_q;
        tdata_d    = tdata_q;
        uf_d       = uf_q;
        ovf_d      = ovf_q | drop;
        if (load) begin
            ob_valid_d = 1'b1;
            if (pop) begin
                tdata_d = lane_beat;
            end else begin
                tdata_d = '0;
                if (uf_q != 16'hFFFF) begin
                    uf_d = uf_q + 16'd1;
                end
            end
        end else if (m_axis_tready) begin
            // Only reached with dac_run low: finish the handshake and stop.
            ob_valid_d = 1'b0;
        end
        if (clr_stat) begin
            uf_d  = '0;
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wclk_s1_q  <= 1'b0;
            wclk_s2_q  <= 1'b0;
            wclk_s3_q  <= 1'b0;
            ptr_q      <= '0;
            hi_q       <= '0;
            toggle_q   <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            ob_valid_q <= 1'b0;
            tdata_q    <= '0;
            ovf_q      <= 1'b0;
            uf_q       <= '0;
        end else begin
            wclk_s1_q  <= gpio_in[24];
            wclk_s2_q  <= wclk_s1_q;
            wclk_s3_q  <= wclk_s2_q;
            ptr_q      <= ptr_d;
            hi_q       <= hi_d;
            toggle_q   <= toggle_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            full_q     <= (count_d == FULL_CNT);
            ob_valid_q <= ob_valid_d;
            tdata_q    <= tdata_d;
            ovf_q      <= ovf_d;
            uf_q       <= uf_d;
        end
    end

    assign m_axis_tdata    = tdata_q;
    assign m_axis_tvalid   = ob_valid_q;
    assign fifo_full       = full_q;
    assign overflow        = ovf_q;
    assign underflow_count = uf_q;

endmodule

// File: tb/tb_dac_driver.sv
`timescale 1ns/1ps
module tb_dac_driver;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  gpio_in;
    logic [7:0]   val_in;
    logic         val_in_valid;
    logic         dac_run;
    logic [127:0] m_axis_tdata;
    logic         m_axis_tvalid;
    logic         m_axis_tready;
    logic         fifo_full;
    logic         overflow;
    logic [15:0]  underflow_count;

    always #5 clk = ~clk;

    dac_driver dut (
        .clk             (clk),
        .rst             (rst),
        .gpio_in         (gpio_in),
        .val_in          (val_in),
        .val_in_valid    (val_in_valid),
        .dac_run         (dac_run),
        .m_axis_tdata    (m_axis_tdata),
        .m_axis_tvalid   (m_axis_tvalid),
        .m_axis_tready   (m_axis_tready),
        .fifo_full       (fifo_full),
        .overflow        (overflow),
        .underflow_count (underflow_count)
    );

    int           checks = 0;
    int           errors = 0;
    logic [127:0] sb [$];
    bit           sb_en = 1'b0;
    logic [15:0]  model_lut [256];
    int           model_ptr = 0;
    bit           model_tog = 1'b0;
    logic [7:0]   model_hi = 8'h00;
    bit           prev_stall = 1'b0;
    logic [127:0] prev_data = '0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] mk_beat(input logic [15:0] s);
        return {16'h0000, s, 96'h0};
    endfunction

    function automatic logic [15:0] ramp(input int k);
        return 16'((k - 128) * 8);
    endfunction

    function automatic logic [127:0] beat_of(input logic [7:0] v);
        return mk_beat(model_lut[v]);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One PS write: w_clk high 3 cycles, low 6, addr/data held throughout.
    task automatic gpio_wr(input logic [15:0] a, input logic [7:0] d);
        gpio_in = {8'h00, d, a};
        tick();
        gpio_in[24] = 1'b1;
        repeat (3) tick();
        gpio_in[24] = 1'b0;
        repeat (6) tick();
        if (a == 16'd0) begin
            model_ptr = int'(d);
            model_tog = 1'b0;
        end else if (a == 16'd1) begin
            if (!model_tog) begin
                model_hi  = d;
                model_tog = 1'b1;
            end else begin
                model_lut[model_ptr] = {model_hi, d};
                model_ptr = (model_ptr + 1) % 256;
                model_tog = 1'b0;
            end
        end
    endtask

    task automatic push_val(input logic [7:0] v, input logic [127:0] exp, input bit track);
        val_in       = v;
        val_in_valid = 1'b1;
        if (track) sb.push_back(exp);
        tick();
        val_in_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 200 && sb.size() != 0; i++) tick();
        check(name, 128'(sb.size()), 128'(0));
    endtask

    task automatic drain_ob();
        dac_run       = 1'b0;
        m_axis_tready = 1'b1;
        repeat (3) tick();
    endtask

    // Monitor: pops expectations on each accepted beat. All-zero beats are
    // idle fills unless the expected head is itself a zero sample.
    always @(negedge clk) begin
        logic [127:0] exp;
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (sb_en && prev_stall && m_axis_tvalid)
                check("tdata_hold", m_axis_tdata, prev_data);
            if (sb_en && m_axis_tvalid && m_axis_tready) begin
                if (sb.size() > 0 && (m_axis_tdata != '0 || sb[0] == '0)) begin
                    exp = sb.pop_front();
                    check("beat", m_axis_tdata, exp);
                end else if (m_axis_tdata != '0) begin
                    check("beat_unexpected", m_axis_tdata, 128'(0));
                end
            end
            prev_stall = m_axis_tvalid && !m_axis_tready;
            prev_data  = m_axis_tdata;
        end
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  v;
        logic [15:0] r;
        rst           = 1'b1;
        gpio_in       = '0;
        val_in        = '0;
        val_in_valid  = 1'b0;
        dac_run       = 1'b0;
        m_axis_tready = 1'b0;
        repeat (3) tick();
        check("rst_tvalid", 128'(m_axis_tvalid), 128'(0));
        check("rst_tdata", m_axis_tdata, 128'(0));
        check("rst_full", 128'(fifo_full), 128'(0));
        check("rst_overflow", 128'(overflow), 128'(0));
        check("rst_underflow", 128'(underflow_count), 128'(0));
        rst = 1'b0;
        tick();

        // LUT load with a ramp, then stream 0..255
        gpio_wr(16'd0, 8'd0);
        for (int k = 0; k < 256; k++) begin
            r = ramp(k);
            gpio_wr(16'd1, r[15:8]);
            gpio_wr(16'd1, r[7:0]);
        end
        sb_en         = 1'b1;
        m_axis_tready = 1'b1;
        dac_run       = 1'b1;
        for (int k = 0; k < 256; k++) push_val(8'(k), mk_beat(ramp(k)), 1'b1);
        wait_drain("ramp_drain");

        // Pointer wrap and toggle reset on pointer write
        gpio_wr(16'd0, 8'hFF);
        gpio_wr(16'd1, 8'hA5);
        gpio_wr(16'd1, 8'h5A);
        gpio_wr(16'd1, 8'h12);
        gpio_wr(16'd1, 8'h34);
        gpio_wr(16'd0, 8'd3);
        gpio_wr(16'd1, 8'hEE);
        gpio_wr(16'd0, 8'd4);
        gpio_wr(16'd1, 8'h00);
        gpio_wr(16'd1, 8'h07);
        gpio_wr(16'd5, 8'h99);
        push_val(8'd255, mk_beat(16'hA55A), 1'b1);
        push_val(8'd0, mk_beat(16'h1234), 1'b1);
        push_val(8'd3, mk_beat(ramp(3)), 1'b1);
        push_val(8'd4, mk_beat(16'h0007), 1'b1);
        push_val(8'd5, mk_beat(ramp(5)), 1'b1);
        wait_drain("wrap_drain");

        // Randomized traffic with random backpressure and run gaps
        for (int i = 0; i < 600; i++) begin
            m_axis_tready = ($urandom_range(0, 3) != 0);
            dac_run       = ($urandom_range(0, 7) != 0);
            if (sb.size() < 12 && $urandom_range(0, 1) == 1) begin
                v = 8'($urandom_range(0, 255));
                val_in       = v;
                val_in_valid = 1'b1;
                sb.push_back(beat_of(v));
            end else begin
                val_in_valid = 1'b0;
            end
            tick();
        end
        val_in_valid  = 1'b0;
        dac_run       = 1'b1;
        m_axis_tready = 1'b1;
        wait_drain("rand_drain");
        check("rand_overflow", 128'(overflow), 128'(0));

        // Backpressure: 10 queued, DAC stalled for 20 cycles
        drain_ob();
        m_axis_tready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            v = 8'(10 * i + 7);
            push_val(v, beat_of(v), 1'b1);
        end
        dac_run = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            check("bp_tvalid", 128'(m_axis_tvalid), 128'(1));
        end
        m_axis_tready = 1'b1;
        wait_drain("bp_drain");

        // Overflow, flush, clear
        drain_ob();
        m_axis_tready = 1'b0;
        sb_en = 1'b0;
        for (int i = 0; i < 20; i++) begin
            push_val(8'(i), '0, 1'b0);
            if (i == 14) check("full_at_15", 128'(fifo_full), 128'(0));
            if (i == 15) begin
                check("full_at_16", 128'(fifo_full), 128'(1));
                check("ovf_at_16", 128'(overflow), 128'(0));
            end
            if (i == 16) check("ovf_at_17", 128'(overflow), 128'(1));
        end
        gpio_wr(16'd2, 8'h01);
        check("flush_full", 128'(fifo_full), 128'(0));
        check("flush_keeps_ovf", 128'(overflow), 128'(1));
        gpio_wr(16'd2, 8'h02);
        check("clr_ovf", 128'(overflow), 128'(0));
        sb_en         = 1'b1;
        m_axis_tready = 1'b1;
        dac_run       = 1'b1;
        repeat (5) tick();
        check("flush_empty_uf", 128'(underflow_count), 128'(5));

        // Underflow count and saturation
        drain_ob();
        gpio_wr(16'd2, 8'h02);
        check("uf_clr", 128'(underflow_count), 128'(0));
        dac_run = 1'b1;
        repeat (50) tick();
        dac_run = 1'b0;
        check("uf_50", 128'(underflow_count), 128'(50));
        tick();
        check("uf_hold_stopped", 128'(underflow_count), 128'(50));
        dac_run = 1'b1;
        repeat (65540) tick();
        check("uf_sat", 128'(underflow_count), 128'(16'hFFFF));
        repeat (2) tick();
        check("uf_sat_hold", 128'(underflow_count), 128'(16'hFFFF));
        drain_ob();
        gpio_wr(16'd2, 8'h02);
        check("uf_clr2", 128'(underflow_count), 128'(0));

        // Run drop with pending beat, then reset mid-stream
        m_axis_tready = 1'b0;
        push_val(8'd40, beat_of(8'd40), 1'b1);
        push_val(8'd50, beat_of(8'd50), 1'b1);
        push_val(8'd60, beat_of(8'd60), 1'b1);
        dac_run = 1'b1;
        tick();
        dac_run = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("stop_tvalid_held", 128'(m_axis_tvalid), 128'(1));
            tick();
        end
        m_axis_tready = 1'b1;
        tick();
        check("stop_tvalid_drop", 128'(m_axis_tvalid), 128'(0));
        m_axis_tready = 1'b0;
        dac_run = 1'b1;
        repeat (2) tick();
        check("pre_rst_tvalid", 128'(m_axis_tvalid), 128'(1));
        #3 rst = 1'b1;
        #1;
        check("rst_async_tvalid", 128'(m_axis_tvalid), 128'(0));
        check("rst_async_tdata", m_axis_tdata, 128'(0));
        sb.delete();
        tick();
        rst = 1'b0;
        m_axis_tready = 1'b1;
        tick();
        check("post_rst_full", 128'(fifo_full), 128'(0));
        check("post_rst_idle", 128'(underflow_count), 128'(1));
        repeat (3) tick();
        dac_run = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
